// File: rtl/rob_writeback_commit_pkg.sv
// rob_writeback_commit_pkg
//   Shared widths and the completion-buffer entry record for the
//   in-order writeback/commit buffer.
package rob_writeback_commit_pkg;

    localparam int WORD_SIZE       = 32;
    localparam int INSTR_TYPE_SZ   = 2;
    localparam int ROB_ENTRY_WITDH = 3;
    localparam int REG_ADDR_SZ     = 5;
    localparam int DEPTH           = 2 ** ROB_ENTRY_WITDH;

    typedef struct packed {
        logic                     busy;
        logic                     done;
        logic [INSTR_TYPE_SZ-1:0] instr_type;
        logic [WORD_SIZE-1:0]     pc;
        logic [REG_ADDR_SZ-1:0]   rd;
        logic [WORD_SIZE-1:0]     result;
    } rob_entry_t;

endpackage

// File: rtl/rob_writeback_commit_ptr_ctrl.sv
// rob_ptr_ctrl
//   Head/tail/count bookkeeping for the completion buffer.
//   Ports:
//     clk, reset        clock, async active-low reset
//     flush             synchronous clear of all pointers
//     alloc_fire        an entry is allocated at this edge
//     commit_fire       the head entry retires at this edge
//     head, tail        retire / allocate pointers (natural wrap)
//     count             occupancy, 0..DEPTH
//     full, empty       occupancy flags
module rob_ptr_ctrl #(
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             alloc_fire,
    input  logic             commit_fire,
    output logic [PTR_W-1:0] head,
    output logic [PTR_W-1:0] tail,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    localparam int CNT_W = PTR_W + 1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // Pointers are exactly PTR_W bits, so +1 wraps DEPTH-1 -> 0.
            if (commit_fire) head <= head + PTR_W'(1);
            if (alloc_fire)  tail <= tail + PTR_W'(1);
            case ({alloc_fire, commit_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CNT_W'(2 ** PTR_W));
    assign empty = (count == '0);

endmodule

// File: rtl/rob_writeback_commit.sv
// rob_writeback_commit
//   In-order completion buffer sitting at the consumer end of the M5->WB
//   writeback path. Issue allocates entries in order, writeback fills them
//   in any order, and entries retire in allocation order, at most one per
//   cycle, through a registered commit port.
//   Ports:
//     clk, reset               clock, async active-low reset
//     flush                    synchronous squash of every entry
//     alloc_*                  allocation request / grant (rob_id = tail)
//     wb_*                     writeback strobe, target id and result
//     commit_*                 registered retire port (valid is a 1-cycle strobe)
//     full, empty              occupancy flags
module rob_writeback_commit
    import rob_writeback_commit_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       alloc_valid,
    input  logic [INSTR_TYPE_SZ-1:0]   alloc_instr_type,
    input  logic [WORD_SIZE-1:0]       alloc_pc,
    input  logic [REG_ADDR_SZ-1:0]     alloc_rd,
    output logic                       alloc_ready,
    output logic [ROB_ENTRY_WITDH-1:0] alloc_rob_id,
    input  logic                       wb_valid,
    input  logic [ROB_ENTRY_WITDH-1:0] wb_rob_id,
    input  logic [WORD_SIZE-1:0]       wb_result,
    output logic                       commit_valid,
    output logic [ROB_ENTRY_WITDH-1:0] commit_rob_id,
    output logic [INSTR_TYPE_SZ-1:0]   commit_instr_type,
    output logic [WORD_SIZE-1:0]       commit_pc,
    output logic [REG_ADDR_SZ-1:0]     commit_rd,
    output logic [WORD_SIZE-1:0]       commit_result,
    output logic                       full,
    output logic                       empty
);

    rob_entry_t                 entries [DEPTH];
    logic [ROB_ENTRY_WITDH-1:0] head;
    logic [ROB_ENTRY_WITDH-1:0] tail;
    logic [ROB_ENTRY_WITDH:0]   count;
    logic                       alloc_fire;
    logic                       commit_fire;
    logic                       wb_fire;

    rob_ptr_ctrl #(
        .PTR_W (ROB_ENTRY_WITDH)
    ) u_ptr (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .alloc_fire  (alloc_fire),
        .commit_fire (commit_fire),
        .head        (head),
        .tail        (tail),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    assign alloc_ready  = !full;
    assign alloc_rob_id = tail;
    assign alloc_fire   = alloc_valid && alloc_ready;

    // Done is only sampled from registered state, so a writeback to the
    // head in the same cycle retires one edge later (no bypass).
    assign commit_fire  = entries[head].busy && entries[head].done;

    // Writebacks to idle entries are dropped so stale results from
    // squashed instructions cannot resurrect a slot.
    assign wb_fire      = wb_valid && entries[wb_rob_id].busy;

    // Only the busy/done control bits are reset; payload fields are always
    // written before they are marked valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].busy <= 1'b0;
                entries[i].done <= 1'b0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].busy <= 1'b0;
                entries[i].done <= 1'b0;
            end
        end else begin
            if (commit_fire) begin
                entries[head].busy <= 1'b0;
            end
            // Allocation never targets the head while it is busy: that
            // would require a full buffer, where alloc_ready is low.
            if (alloc_fire) begin
                entries[tail].busy       <= 1'b1;
                entries[tail].done       <= 1'b0;
                entries[tail].instr_type <= alloc_instr_type;
                entries[tail].pc         <= alloc_pc;
                entries[tail].rd         <= alloc_rd;
            end
            if (wb_fire) begin
                entries[wb_rob_id].done   <= 1'b1;
                entries[wb_rob_id].result <= wb_result;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            commit_valid      <= 1'b0;
            commit_rob_id     <= '0;
            commit_instr_type <= '0;
            commit_pc         <= '0;
            commit_rd         <= '0;
            commit_result     <= '0;
        end else if (flush) begin
            commit_valid <= 1'b0;
        end else if (commit_fire) begin
            commit_valid      <= 1'b1;
            commit_rob_id     <= head;
            commit_instr_type <= entries[head].instr_type;
            commit_pc         <= entries[head].pc;
            commit_rd         <= entries[head].rd;
            commit_result     <= entries[head].result;
        end else begin
            // Payload holds its last retired value; only the strobe drops.
            commit_valid <= 1'b0;
        end
    end

endmodule
